// File: rtl/fp_mult_sequencer_if.sv
// Handshake bundle for fp_mult_sequencer: operand input, multiplier side-channel and result output.
interface fp_mult_sequencer_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned PEND_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;

  logic              mul_start;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic              mul_ready;
  logic              mul_busy;
  logic [31:0]       mul_y;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_y;
  logic              out_nan;
  logic              out_inf;
  logic              out_zero;
  logic              out_timeout;
  logic [PEND_W-1:0] pending;

  modport slave (
    input  in_valid, in_a, in_b, mul_ready, mul_busy, mul_y, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_y,
           out_nan, out_inf, out_zero, out_timeout, pending
  );

  modport master (
    output in_valid, in_a, in_b, mul_ready, mul_busy, mul_y, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_y,
           out_nan, out_inf, out_zero, out_timeout, pending
  );
endinterface

// File: rtl/fp_mult_sequencer.sv
// Queues FP32 operand pairs and feeds them one at a time to an external multiplier,
// holding each result (with class flags) until the consumer accepts it.
module fp_mult_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  fp_mult_sequencer_if.slave bus
);
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TIMEOUT_Y = 32'h7F80_0001;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               mul_start_q, mul_start_d;
  logic [31:0]        mul_a_q, mul_a_d;
  logic [31:0]        mul_b_q, mul_b_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_y_q, out_y_d;
  logic               nan_q, nan_d;
  logic               inf_q, inf_d;
  logic               zero_q, zero_d;
  logic               timeout_q, timeout_d;

  logic [63:0]        mem_q [DEPTH];
  logic [63:0]        head;
  logic               push;
  logic               pop;
  logic               load;
  logic               cap_to;
  logic [31:0]        cap_y;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    nan_d       = nan_q;
    inf_d       = inf_q;
    zero_d      = zero_q;
    timeout_d   = timeout_q;
    push        = bus.in_valid && in_ready_q;
    pop         = 1'b0;
    load        = 1'b0;
    cap_to      = 1'b0;
    cap_y       = '0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    // mul_start is registered, so the head is popped on the edge entering ISSUE
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !out_valid_q && !bus.mul_busy) begin
          pop         = 1'b1;
          mul_a_d     = head[63:32];
          mul_b_d     = head[31:0];
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.mul_ready) begin
          load    = 1'b1;
          cap_y   = bus.mul_y;
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          load    = 1'b1;
          cap_y   = TIMEOUT_Y;
          cap_to  = 1'b1;
          state_d = DRAIN;
        end else begin
          tmo_cnt_d = TMO_W'(tmo_cnt_q + 1'b1);
        end
      end
      DRAIN: begin
        if (!bus.mul_busy && !bus.mul_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_y_d     = cap_y;
      nan_d       = (cap_y[30:23] == 8'hFF) && (cap_y[22:0] != 23'h0);
      inf_d       = (cap_y[30:23] == 8'hFF) && (cap_y[22:0] == 23'h0);
      zero_d      = (cap_y[30:23] == 8'h00) && (cap_y[22:0] == 23'h0);
      timeout_d   = cap_to;
    end

    wr_ptr_d   = PTR_W'(wr_ptr_q + PTR_W'(push));
    rd_ptr_d   = PTR_W'(rd_ptr_q + PTR_W'(pop));
    count_d    = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
    in_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
      zero_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_cnt_q   <= tmo_cnt_d;
      in_ready_q  <= in_ready_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
      zero_q      <= zero_d;
      timeout_q   <= timeout_d;
    end
  end

  // Operand storage needs no reset; the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mul_start   = mul_start_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_y       = out_y_q;
  assign bus.out_nan     = nan_q;
  assign bus.out_inf     = inf_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_timeout = timeout_q;
  assign bus.pending     = count_q;
endmodule
